// File: rtl/fnd_pkg.sv
// Shared constants and types for the 4-digit FND scan controller.
// Segment patterns are active-low, ordered {dp,g,f,e,d,c,b,a}.
package fnd_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [13:0] MAX_DISPLAY = 14'd9999;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_SEC  = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_HOUR = 3'd3
    } watch_state_e;

    // Per-frame copy of everything the displayed digits depend on
    typedef struct packed {
        logic [13:0] data;
        logic [6:0]  msec;
        logic [2:0]  state;
        logic        sw;
    } snap_t;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = SEG_0;
            4'd1:    seg_code = SEG_1;
            4'd2:    seg_code = SEG_2;
            4'd3:    seg_code = SEG_3;
            4'd4:    seg_code = SEG_4;
            4'd5:    seg_code = SEG_5;
            4'd6:    seg_code = SEG_6;
            4'd7:    seg_code = SEG_7;
            4'd8:    seg_code = SEG_8;
            4'd9:    seg_code = SEG_9;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Digit + dot + blank -> active-low 7-segment pattern (combinational).
module fnd_seg_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    // Blank overrides everything, including the dot
    always_comb begin
        seg = seg_code(digit);
        if (dp)    seg[7] = 1'b0;
        if (blank) seg = SEG_BLANK;
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit common-anode FND scanner: divider, digit select, per-frame
// snapshot, digit extraction, dot blink and edit-pair blink.
// Optional feature macro: FND_SET_BLINK_EN (blank the digit pair being edited).
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] i_data,
    input  logic [6:0]  i_msec,
    input  logic [2:0]  i_watch_state,
    input  logic        i_display_switch,
    output logic [3:0]  o_fnd_com,
    output logic [7:0]  o_fnd_data
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = $clog2(DIV);

    logic [CW-1:0]   cnt;
    logic            tick;
    logic [1:0]      sel, sel_nxt;
    logic            load;
    snap_t           snap, snap_in, snap_cur;
    logic [13:0]     v;
    logic [3:0][3:0] dig;
    logic [3:0][7:0] seg;
    logic            off;
    logic            blank_lo, blank_hi;

    assign tick    = (cnt == CW'(DIV - 1));
    assign sel_nxt = sel + 2'd1;
    assign load    = tick && (sel == 2'd3);
    assign snap_in = '{data: i_data, msec: i_msec, state: i_watch_state, sw: i_display_switch};
    // Digit 0 of a new frame must already reflect the values being captured
    assign snap_cur = load ? snap_in : snap;

    // Scan-rate divider
    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

    // Digit select and frame snapshot advance on tick
    always_ff @(posedge clk) begin
        if (rst) begin
            sel  <= 2'd3;
            snap <= '0;
        end else if (tick) begin
            sel <= sel_nxt;
            if (load) snap <= snap_in;
        end
    end

    // Clamp and split into decimal digits
    always_comb begin
        v      = (snap_cur.data > MAX_DISPLAY) ? MAX_DISPLAY : snap_cur.data;
        dig[0] = 4'(v % 14'd10);
        dig[1] = 4'((v / 14'd10) % 14'd10);
        dig[2] = 4'((v / 14'd100) % 14'd10);
        dig[3] = 4'(v / 14'd1000);
    end

    assign off = (snap_cur.msec >= 7'd50);

`ifdef FND_SET_BLINK_EN
    // Blank the pair under edit during the off half-second
    always_comb begin
        blank_lo = 1'b0;
        blank_hi = 1'b0;
        if (off) begin
            if (snap_cur.state == ST_SET_SEC  &&  snap_cur.sw) blank_hi = 1'b1;
            if (snap_cur.state == ST_SET_MIN  && !snap_cur.sw) blank_lo = 1'b1;
            if (snap_cur.state == ST_SET_HOUR && !snap_cur.sw) blank_hi = 1'b1;
        end
    end
`else
    logic unused_edit;
    assign unused_edit = ^{snap_cur.state, snap_cur.sw};
    assign blank_lo    = 1'b0;
    assign blank_hi    = 1'b0;
`endif

    // One decoder per digit position; dot only on digit 2
    for (genvar g = 0; g < 4; g++) begin : g_dec
        fnd_seg_decoder u_dec (
            .digit (dig[g]),
            .dp    ((g == 2) ? ~off : 1'b0),
            .blank ((g >= 2) ? blank_hi : blank_lo),
            .seg   (seg[g])
        );
    end

    // Registered pin drive, updated only on tick
    always_ff @(posedge clk) begin
        if (rst) begin
            o_fnd_com  <= 4'b1111;
            o_fnd_data <= SEG_BLANK;
        end else if (tick) begin
            o_fnd_com  <= ~(4'b0001 << sel_nxt);
            o_fnd_data <= seg[sel_nxt];
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl at DIV = 4 (one frame = 16 cycles).
module tb_fnd_scan_ctrl;

`ifdef FND_SET_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [3:0] com;
        logic [7:0] data;
        int         gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] i_data = '0;
    logic [6:0]  i_msec = '0;
    logic [2:0]  i_watch_state = '0;
    logic        i_display_switch = 1'b0;
    logic [3:0]  o_fnd_com;
    logic [7:0]  o_fnd_data;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    bit          stop = 1'b0;
    int          cyc = 0;
    int          last_cyc = 0;
    logic [11:0] prev = 'x;

    fnd_scan_ctrl #(.CLK_HZ(400), .SCAN_HZ(100)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_data           (i_data),
        .i_msec           (i_msec),
        .i_watch_state    (i_watch_state),
        .i_display_switch (i_display_switch),
        .o_fnd_com        (o_fnd_com),
        .o_fnd_data       (o_fnd_data)
    );

    always #5 clk = ~clk;

    // Cycles since the last edge that sampled rst high
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Monitor: every output change pops one expected entry
    always @(negedge clk) begin
        exp_t e;
        if (!stop && ({o_fnd_com, o_fnd_data} !== prev)) begin
            prev = {o_fnd_com, o_fnd_data};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change got com=%b data=%h", o_fnd_com, o_fnd_data);
            end else begin
                e = q.pop_front();
                if ({o_fnd_com, o_fnd_data} !== {e.com, e.data}) begin
                    errors++;
                    $display("FAIL %s got com=%b data=%h want com=%b data=%h",
                             e.name, o_fnd_com, o_fnd_data, e.com, e.data);
                end
                if (e.gap != 0) begin
                    checks++;
                    if (cyc - last_cyc != e.gap) begin
                        errors++;
                        $display("FAIL %s_hold got %0d cycles want %0d", e.name, cyc - last_cyc, e.gap);
                    end
                end
            end
            last_cyc = cyc;
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input logic [3:0] com, input logic [7:0] data, input int gap);
        exp_t e;
        e.name = name; e.com = com; e.data = data; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic set_in(input logic [13:0] d, input logic [6:0] m, input logic [2:0] st, input logic sw);
        i_data = d; i_msec = m; i_watch_state = st; i_display_switch = sw;
    endtask

    // Apply inputs ahead of a frame start and expect its four digits
    task automatic frame(input string name, input logic [13:0] d, input logic [6:0] m,
                         input logic [2:0] st, input logic sw,
                         input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3);
        set_in(d, m, st, sw);
        push({name, "_d0"}, 4'b1110, s0, 4);
        push({name, "_d1"}, 4'b1101, s1, 4);
        push({name, "_d2"}, 4'b1011, s2, 4);
        push({name, "_d3"}, 4'b0111, s3, 4);
        cyc_wait(16);
    endtask

    initial begin
        set_in(14'd1234, 7'd70, 3'd0, 1'b0);
        push("reset", 4'b1111, 8'hFF, 0);
        cyc_wait(3);
        rst = 1'b0;

        frame("scan_off",   14'd1234,  7'd70, 3'd0, 1'b0, 8'h99, 8'hB0, 8'hA4, 8'hF9);
        frame("dp_on",      14'd1234,  7'd10, 3'd0, 1'b0, 8'h99, 8'hB0, 8'h24, 8'hF9);
        frame("clamp",      14'd16383, 7'd0,  3'd0, 1'b0, 8'h90, 8'h90, 8'h10, 8'h90);
        frame("zero",       14'd0,     7'd49, 3'd0, 1'b0, 8'hC0, 8'hC0, 8'h40, 8'hC0);
        frame("min_off",    14'd1234,  7'd60, 3'd2, 1'b0,
              BLINK ? 8'hFF : 8'h99, BLINK ? 8'hFF : 8'hB0, 8'hA4, 8'hF9);
        frame("min_on",     14'd1234,  7'd20, 3'd2, 1'b0, 8'h99, 8'hB0, 8'h24, 8'hF9);
        frame("hour_off",   14'd1234,  7'd60, 3'd3, 1'b0,
              8'h99, 8'hB0, BLINK ? 8'hFF : 8'hA4, BLINK ? 8'hFF : 8'hF9);
        frame("sec_50",     14'd1234,  7'd50, 3'd1, 1'b1,
              8'h99, 8'hB0, BLINK ? 8'hFF : 8'hA4, BLINK ? 8'hFF : 8'hF9);
        frame("sec_sw0",    14'd1234,  7'd60, 3'd1, 1'b0, 8'h99, 8'hB0, 8'hA4, 8'hF9);
        frame("min_sw1",    14'd1234,  7'd60, 3'd2, 1'b1, 8'h99, 8'hB0, 8'hA4, 8'hF9);
        frame("state7",     14'd1234,  7'd60, 3'd7, 1'b0, 8'h99, 8'hB0, 8'hA4, 8'hF9);

        // Input change at sel = 1 must not tear the current frame
        set_in(14'd1234, 7'd70, 3'd0, 1'b0);
        push("snap_d0", 4'b1110, 8'h99, 4);
        push("snap_d1", 4'b1101, 8'hB0, 4);
        push("snap_d2", 4'b1011, 8'hA4, 4);
        push("snap_d3", 4'b0111, 8'hF9, 4);
        cyc_wait(8);
        i_data = 14'd5678;
        cyc_wait(8);
        frame("snap_next",  14'd5678,  7'd70, 3'd0, 1'b0, 8'h80, 8'hF8, 8'h82, 8'h92);

        // One-cycle reset while digit 2 is shown
        push("mid_d0", 4'b1110, 8'h80, 4);
        push("mid_d1", 4'b1101, 8'hF8, 4);
        push("mid_d2", 4'b1011, 8'h82, 4);
        cyc_wait(12);
        rst = 1'b1;
        push("rst_mid", 4'b1111, 8'hFF, 0);
        cyc_wait(1);
        rst = 1'b0;
        frame("after_rst",  14'd1234,  7'd10, 3'd0, 1'b0, 8'h99, 8'hB0, 8'h24, 8'hF9);

        cyc_wait(1);
        stop = 1'b1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Display consumer for the clock's time-keeping core. Takes the 14-bit 4-digit value, the hundredths count, the set-mode state and the display-page select, then drives a 4-digit common-anode 7-segment module by time-multiplexed scanning. Provides the separator dot blink and the blink of the digit pair being edited. Sits between the watch top and the board FND pins.

## Interface
- CLK_HZ, 100_000_000, system clock frequency.
- SCAN_HZ, 1000, digit-advance rate. DIV = CLK_HZ/SCAN_HZ must be ≥ 2.
- clk  in  1  system clock; the block's only clock.
- rst  in  1  reset: synchronous, active-high.
- i_data  in  14  display value, nominally 0..9999.
- i_msec  in  7  hundredths of a second, 0..99.
- i_watch_state  in  3  0 = run, 1 = set sec, 2 = set min, 3 = set hour; 4..7 are treated as run.
- i_display_switch  in  1  1 = sec.msec page, 0 = hour.min page.
- o_fnd_com  out  4  digit enables, active-low; bit0 is the rightmost digit.
- o_fnd_data  out  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}.

## Operation
- **Divider:** counts 0..DIV-1 and wraps. `tick` is a 1-cycle pulse when count == DIV-1.
- **Digit select:** 2-bit `sel` register, reset value 3.
  - Each tick: sel ← sel+1 (3 wraps to 0).
  - On the same edge, o_fnd_com ← ~(1 << new sel) and o_fnd_data ← the pattern for digit[new sel].
- **Frame snapshot:** on the tick where sel becomes 0, register i_data, i_msec, i_watch_state and i_display_switch. Digits are computed only from the snapshot, so there is no tearing within a frame. The snapshot resets to all-zero.
- **Digit extraction:**
  - Clamp: v = (snap_data > 9999) ? 9999 : snap_data.
  - d0 = v%10, d1 = (v/10)%10, d2 = (v/100)%10, d3 = v/1000.
- **Blink phase:** `off` = (snap_msec ≥ 50).
- **Dot:** dp is lit only on digit 2, only when !off.
- **Edit blink (macro-gated):** the digit pair under edit is forced blank (8'hFF, dp included) while off.
  - state 1 and switch 1 → digits 3:2.
  - state 2 and switch 0 → digits 1:0.
  - state 3 and switch 0 → digits 3:2.
  - Any other combination: no blanking.
- **Segment codes 0..9:** C0, F9, A4, B0, 99, 92, 82, F8, 80, 90. A lit dp clears bit 7.

## Timing
- **Reset values:** o_fnd_com = 4'b1111, o_fnd_data = 8'hFF, divider = 0, sel = 3, snapshot = 0.
  - First tick occurs DIV cycles after rst deasserts. It selects digit 0 and loads the snapshot.
- **Outputs:** registered. They change only on tick edges and are held for exactly DIV cycles.
- **Input latency:** an input change is visible at the next sel→0 tick, i.e. at most 4·DIV + 1 cycles later.
- **rst mid-scan:** the next edge returns all registers to reset values, regardless of tick.
- **Frame rate:** SCAN_HZ/4 (250 Hz default).

## Configuration
- **FND_SET_BLINK_EN defined:** edit-pair blanking as described in Operation.
- **Undefined:** i_watch_state is ignored and all digits are always shown. Dot blink is unaffected.

## Structure
- **Package `fnd_pkg`:**
  - SEG_0..SEG_9 and SEG_BLANK constants.
  - State encodings ST_RUN, ST_SET_SEC, ST_SET_MIN, ST_SET_HOUR.
  - MAX_DISPLAY = 9999.
- **Sub-module `fnd_seg_decoder`:** combinational 4-bit digit + dp + blank → 8-bit active-low pattern.

## Test plan
All scenarios use CLK_HZ = 400 and SCAN_HZ = 100 (DIV = 4).
- **Reset:** hold rst → o_fnd_com = 1111 and o_fnd_data = FF. After release, first change occurs 4 cycles later with com = 1110.
- **Basic scan:** i_data = 1234, i_msec = 70, state 0.
  - Successive ticks give com/data 1110/99, 1101/B0, 1011/A4, 0111/F9.
  - With i_msec = 10, digit 2 shows 24.
- **Clamp:** i_data = 16383, i_msec = 0 → digits show 90, 90, 10, 90 (dp lit on digit 2).
- **Edit blink:** state 2, switch 0, i_data = 1234.
  - i_msec = 60 → digits 1:0 show FF, digits 3:2 show A4, F9.
  - i_msec = 20 → all digits shown, digit 2 = 24.
  - Repeat with the macro undefined → never blank.
- **Snapshot:** change i_data from 1234 to 5678 while sel = 1 → remaining digits of that frame still show 1234. The next frame shows 5678.
- **Reset mid-scan:** pulse rst for 1 cycle at sel = 2 → next edge gives com = 1111 and data = FF. Scanning restarts at digit 0 after 4 cycles.
